// File: rtl/mem_port_arbiter.sv
// Arbiter for the single shared memory port: grants fetch or MEM stage, holds the
// command until the memory acknowledges, and builds the pipeline stall vector.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ms_req,
  input  logic              ms_we,
  input  logic [ADDR_W-1:0] ms_addr,
  input  logic [DATA_W-1:0] ms_wdata,
  input  logic [3:0]        ms_mask,
  output logic [DATA_W-1:0] ms_rdata,
  output logic              ms_done,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_mask,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic [5:0]        stall
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MS_BUSY, RESP} state_t;

  state_t state, state_nx;
  logic   grant_ms, grant_if, complete;

  always_comb begin
    state_nx = state;
    grant_ms = 1'b0;
    grant_if = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (ms_req) begin
          grant_ms = 1'b1;
          state_nx = MS_BUSY;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_nx = IF_BUSY;
        end
      end
      IF_BUSY, MS_BUSY: begin
        if (ram_ready) begin
          complete = 1'b1;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Memory command: loaded on grant, held untouched until the acknowledge edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_mask  <= 4'h0;
    end else if (grant_ms) begin
      ram_req   <= 1'b1;
      ram_we    <= ms_we;
      ram_addr  <= ms_addr;
      ram_wdata <= ms_wdata;
      ram_mask  <= ms_mask;
    end else if (grant_if) begin
      ram_req   <= 1'b1;
      ram_we    <= 1'b0;
      ram_addr  <= if_addr;
      ram_wdata <= '0;
      ram_mask  <= 4'hF;
    end else if (complete) begin
      ram_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_done  <= 1'b0;
      ms_done  <= 1'b0;
      if_rdata <= '0;
      ms_rdata <= '0;
    end else begin
      if_done <= complete && (state == IF_BUSY);
      ms_done <= complete && (state == MS_BUSY);
      if (complete && (state == IF_BUSY)) if_rdata <= ram_rdata;
      // Stores leave the last load result visible.
      if (complete && (state == MS_BUSY) && !ram_we) ms_rdata <= ram_rdata;
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (!rst)                      stall = 6'b000000;
    else if (ms_req && !ms_done)   stall = 6'b011111;
    else if (stallreq_ex)          stall = 6'b001111;
    else if (stallreq_id)          stall = 6'b000111;
    else if (if_req && !if_done)   stall = 6'b000011;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: stall table, directed corner sequences and
// randomized requesters/memory against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ms_req, ms_we, stallreq_id, stallreq_ex, ram_ready;
  logic [31:0] if_addr, ms_addr, ms_wdata, ram_rdata;
  logic [3:0]  ms_mask;
  logic [31:0] if_rdata, ms_rdata, ram_addr, ram_wdata;
  logic        if_done, ms_done, ram_req, ram_we;
  logic [3:0]  ram_mask;
  logic [5:0]  stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ms_req(ms_req), .ms_we(ms_we), .ms_addr(ms_addr), .ms_wdata(ms_wdata),
    .ms_mask(ms_mask), .ms_rdata(ms_rdata), .ms_done(ms_done),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_mask(ram_mask), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .stall(stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, a dead cycle after each completion.
  bit          m_busy, m_is_ms, m_gap, m_fresh;
  logic        m_we, m_if_done, m_ms_done;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_ms_rdata;
  logic [3:0]  m_mask;

  task automatic model_reset();
    m_busy = 0; m_is_ms = 0; m_gap = 0; m_fresh = 1;
    m_we = 0; m_addr = 0; m_wdata = 0; m_mask = 0;
    m_if_done = 0; m_ms_done = 0; m_if_rdata = 0; m_ms_rdata = 0;
  endtask

  function automatic logic [31:0] exp_stall();
    if (!rst)                      return 32'h00;
    if (ms_req && !m_ms_done)      return 32'h1F;
    if (stallreq_ex)               return 32'h0F;
    if (stallreq_id)               return 32'h07;
    if (if_req && !m_if_done)      return 32'h03;
    return 32'h00;
  endfunction

  task automatic model_step();
    if (!rst) begin
      model_reset();
      return;
    end
    m_if_done = 0;
    m_ms_done = 0;
    if (m_busy) begin
      if (ram_ready) begin
        if (m_is_ms) begin
          m_ms_done = 1;
          if (!m_we) m_ms_rdata = ram_rdata;
        end else begin
          m_if_done = 1;
          m_if_rdata = ram_rdata;
        end
        m_busy = 0;
        m_gap  = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (ms_req) begin
      m_busy = 1; m_is_ms = 1; m_fresh = 0;
      m_we = ms_we; m_addr = ms_addr; m_wdata = ms_wdata; m_mask = ms_mask;
    end else if (if_req) begin
      m_busy = 1; m_is_ms = 0; m_fresh = 0;
      m_we = 0; m_addr = if_addr; m_mask = 4'hF;
    end
  endtask

  task automatic compare();
    chk("ram_req", 32'(ram_req), 32'(m_busy));
    chk("if_done", 32'(if_done), 32'(m_if_done));
    chk("ms_done", 32'(ms_done), 32'(m_ms_done));
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("ms_rdata", ms_rdata, m_ms_rdata);
    chk("stall", 32'(stall), exp_stall());
    if (m_busy || m_fresh) begin
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_we", 32'(ram_we), 32'(m_we));
      chk("ram_mask", 32'(ram_mask), 32'(m_mask));
      if (m_fresh || m_is_ms) chk("ram_wdata", ram_wdata, m_wdata);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cyc();
    if (!rst) model_reset();
    #1;
    compare();
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic       ms_r, if_r, ex, id;
    logic [5:0] exp;
  } svec_t;
  svec_t tbl[8];

  int done_cnt;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000111};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b001111};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000011};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b000111};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b011111};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};

    rst = 0; if_req = 0; ms_req = 0; ms_we = 0; stallreq_id = 0; stallreq_ex = 0;
    ram_ready = 0; if_addr = 0; ms_addr = 0; ms_wdata = 0; ms_mask = 0; ram_rdata = 0;
    model_reset();
    @(negedge clk);
    cyc();
    ram_ready = 1;
    cyc();
    ram_ready = 0;
    rst = 1;
    cyc();

    // Combinational stall priority, inputs withdrawn before the next rising edge.
    for (int i = 0; i < 8; i++) begin
      ms_req = tbl[i].ms_r; if_req = tbl[i].if_r;
      stallreq_ex = tbl[i].ex; stallreq_id = tbl[i].id;
      #1;
      chk($sformatf("stall_tbl%0d", i), 32'(stall), 32'(tbl[i].exp));
      ms_req = 0; if_req = 0; stallreq_ex = 0; stallreq_id = 0;
      cyc();
    end

    // Single fetch with minimum latency.
    if_req = 1; if_addr = 32'h100;
    cyc();
    chk("fetch_addr", ram_addr, 32'h100);
    chk("fetch_we", 32'(ram_we), 32'h0);
    chk("fetch_stall_wait", 32'(stall), 32'h03);
    ram_ready = 1; ram_rdata = 32'hDEADBEEF;
    cyc();
    chk("fetch_done", 32'(if_done), 32'h1);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
    chk("fetch_stall_done", 32'(stall), 32'h00);
    if_req = 0; ram_ready = 0;
    cyc(); cyc();

    // Simultaneous requests: MEM stage first, fetch granted two cycles after ms_done.
    if_req = 1; if_addr = 32'h200;
    ms_req = 1; ms_we = 0; ms_addr = 32'h2000; ms_mask = 4'hF; ms_wdata = 32'h0;
    cyc();
    chk("tie_ms_first", ram_addr, 32'h2000);
    chk("tie_stall", 32'(stall), 32'h1F);
    ram_ready = 1; ram_rdata = 32'hCAFEF00D;
    cyc();
    chk("tie_ms_done", 32'(ms_done), 32'h1);
    chk("tie_ms_rdata", ms_rdata, 32'hCAFEF00D);
    chk("tie_stall_fetch", 32'(stall), 32'h03);
    ms_req = 0; ram_ready = 0;
    cyc();
    chk("tie_gap", 32'(ram_req), 32'h0);
    cyc();
    chk("tie_if_grant", 32'(ram_req), 32'h1);
    chk("tie_if_addr", ram_addr, 32'h200);
    ram_ready = 1; ram_rdata = 32'h11112222;
    cyc();
    chk("tie_if_done", 32'(if_done), 32'h1);
    if_req = 0; ram_ready = 0;
    cyc(); cyc();

    // Store with a slow memory: command stable, one done pulse, load data untouched.
    done_cnt = 0;
    ms_req = 1; ms_we = 1; ms_addr = 32'h3000; ms_wdata = 32'h12345678; ms_mask = 4'b0011;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("st_hold_req", 32'(ram_req), 32'h1);
      chk("st_hold_addr", ram_addr, 32'h3000);
      chk("st_hold_wdata", ram_wdata, 32'h12345678);
      chk("st_hold_mask", 32'(ram_mask), 32'h3);
      chk("st_hold_we", 32'(ram_we), 32'h1);
      done_cnt += int'(ms_done);
      cyc();
    end
    ram_ready = 1; ram_rdata = 32'hBAD0BAD0;
    cyc();
    done_cnt += int'(ms_done);
    chk("st_rdata_kept", ms_rdata, 32'hCAFEF00D);
    ms_req = 0; ram_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      done_cnt += int'(ms_done);
    end
    chk("st_one_done", 32'(done_cnt), 32'h1);

    // No preemption of a fetch in progress.
    if_req = 1; if_addr = 32'h400;
    cyc();
    ms_req = 1; ms_we = 0; ms_addr = 32'h5000; ms_mask = 4'hF;
    cyc();
    chk("np_keep_if", ram_addr, 32'h400);
    cyc();
    ram_ready = 1; ram_rdata = 32'h44444444;
    cyc();
    chk("np_if_done", 32'(if_done), 32'h1);
    chk("np_no_ms_done", 32'(ms_done), 32'h0);
    if_req = 0; ram_ready = 0;
    cyc(); cyc();
    chk("np_ms_grant", ram_addr, 32'h5000);
    ram_ready = 1; ram_rdata = 32'h55555555;
    cyc();
    chk("np_ms_done", 32'(ms_done), 32'h1);
    ms_req = 0; ram_ready = 0;
    cyc(); cyc();

    // Reset during MS_BUSY, then a stray ready.
    ms_req = 1; ms_we = 0; ms_addr = 32'h6000; ms_mask = 4'hF;
    cyc();
    chk("rst_pre_busy", 32'(ram_req), 32'h1);
    rst = 0; ms_req = 0;
    #1;
    chk("rst_req", 32'(ram_req), 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_mask", 32'(ram_mask), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ms_rdata", ms_rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    cyc();
    rst = 1; ram_ready = 1; ram_rdata = 32'h66666666;
    cyc();
    chk("rst_no_done", 32'(ms_done), 32'h0);
    ram_ready = 0;
    cyc();
    chk("rst_no_done2", 32'(ms_done), 32'h0);
    chk("rst_idle", 32'(ram_req), 32'h0);
    chk("rst_rdata_clear", ms_rdata, 32'h0);

    // Randomized requesters and memory.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      if (!rst) begin
        if_req = 0; ms_req = 0;
      end else begin
        if (if_req) begin
          if (m_if_done && $urandom_range(0, 1) == 0) if_req = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (ms_req) begin
          if (m_ms_done && $urandom_range(0, 1) == 0) ms_req = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          ms_req = 1; ms_we = ($urandom_range(0, 1) == 1);
          ms_addr = $urandom; ms_wdata = $urandom; ms_mask = 4'($urandom);
        end
      end
      stallreq_id = ($urandom_range(0, 3) == 0);
      stallreq_ex = ($urandom_range(0, 4) == 0);
      ram_ready   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      ram_rdata   = $urandom;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
